display_scan_ctrl: RTL and testbench

//   Time-multiplexes NUM_DIGITS BCD digits of the watch display (HH:MM:SS) onto one

---
 rtl/display_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Purpose: scans NUM_DIGITS BCD digits onto one shared 7-seg decoder with guard gaps, frame snapshot and blink.
// Latency: all outputs registered; en sampled at edge N drives the first guard slot from edge N+1.
// Backpressure: none; en=0 darkens the display on the next clock and clears the scan position.
module display_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD_CYC    = 8,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  output logic [3:0]              dec_code,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick,
  output logic                    blink_phase
);

  localparam int unsigned CW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_GUARD = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t                         state, n_state;
  logic [CW-1:0]                  cnt, n_cnt;
  logic [IW-1:0]                  idx, n_idx;
  logic [BW-1:0]                  bcnt, n_bcnt;
  logic                           n_phase;
  logic [NUM_DIGITS-1:0][3:0]     snap, n_snap;
  logic                           n_tick;
  logic [NUM_DIGITS-1:0]          n_sel;
  logic [3:0]                     n_code;
  logic [3:0]                     n_digit;

  // Next scan position, snapshot and blink state; outputs are derived from the
  // next-state values so the registered outputs always line up with the state.
  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_idx   = idx;
    n_bcnt  = bcnt;
    n_phase = blink_phase;
    n_snap  = snap;
    n_tick  = 1'b0;
    n_sel   = '1;
    n_code  = 4'hF;
    n_digit = 4'h0;

    if (state == S_OFF) begin
      if (en) begin
        n_state = S_GUARD;
        n_cnt   = '0;
        n_idx   = '0;
        n_snap  = digits_in;
      end
    end else if (!en) begin
      // Partial frame is abandoned silently; blink_phase keeps its value.
      n_state = S_OFF;
      n_cnt   = '0;
      n_idx   = '0;
      n_bcnt  = '0;
    end else begin
      if (cnt == CW'(SCAN_DIV - 1)) begin
        n_cnt = '0;
        if (idx == IW'(NUM_DIGITS - 1)) begin
          // Frame boundary: the only point where digits and blink phase may change.
          n_idx  = '0;
          n_tick = 1'b1;
          n_snap = digits_in;
          if (bcnt == BW'(BLINK_FRAMES - 1)) begin
            n_bcnt  = '0;
            n_phase = ~blink_phase;
          end else begin
            n_bcnt = bcnt + 1'b1;
          end
        end else begin
          n_idx = idx + 1'b1;
        end
      end else begin
        n_cnt = cnt + 1'b1;
      end
      n_state = (n_cnt < CW'(GUARD_CYC)) ? S_GUARD : S_DRIVE;
    end

    if (n_state == S_DRIVE) begin
      n_sel   = ~(NUM_DIGITS'(1) << n_idx);
      n_digit = n_snap[n_idx];
      if ((n_phase && blink_mask[n_idx]) ||
          (lz_en && (n_idx == IW'(NUM_DIGITS - 1)) && (n_digit == 4'h0))) begin
        n_code = 4'hF;
      end else begin
        n_code = n_digit;
      end
    end
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_OFF;
      cnt         <= '0;
      idx         <= '0;
      bcnt        <= '0;
      snap        <= '0;
      blink_phase <= 1'b0;
      frame_tick  <= 1'b0;
      dig_sel     <= '1;
      dec_code    <= 4'hF;
    end else begin
      state       <= n_state;
      cnt         <= n_cnt;
      idx         <= n_idx;
      bcnt        <= n_bcnt;
      snap        <= n_snap;
      blink_phase <= n_phase;
      frame_tick  <= n_tick;
      dig_sel     <= n_sel;
      dec_code    <= n_code;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Purpose: directed self-checking bench for display_scan_ctrl (SCAN_DIV=4, GUARD_CYC=1, 6 digits, BLINK_FRAMES=2).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable; en toggled directly by the stimulus.
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [23:0] digits_in;
  logic [5:0]  blink_mask;
  logic        lz_en;
  logic [3:0]  dec_code;
  logic [5:0]  dig_sel;
  logic        frame_tick;
  logic        blink_phase;

  int tests = 0;
  int fails = 0;

  display_scan_ctrl #(
    .NUM_DIGITS  (6),
    .SCAN_DIV    (4),
    .GUARD_CYC   (1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits_in  (digits_in),
    .blink_mask (blink_mask),
    .lz_en      (lz_en),
    .dec_code   (dec_code),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick),
    .blink_phase(blink_phase)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One slot: a single guard clock followed by three drive clocks of digit i.
  task automatic slot(input int i, input logic [3:0] code, input logic tick, input logic ph);
    logic [5:0] sel_exp;
    sel_exp = ~(6'b000001 << i);
    step();
    chk("guard_sel",   {2'b00, dig_sel}, 8'h3F);
    chk("guard_code",  {4'h0, dec_code}, 8'h0F);
    chk("guard_tick",  {7'd0, frame_tick}, {7'd0, tick});
    chk("guard_phase", {7'd0, blink_phase}, {7'd0, ph});
    for (int k = 0; k < 3; k++) begin
      step();
      chk("drive_sel",  {2'b00, dig_sel}, {2'b00, sel_exp});
      chk("drive_code", {4'h0, dec_code}, {4'h0, code});
      chk("drive_tick", {7'd0, frame_tick}, 8'h00);
    end
  endtask

  // Whole frame; codes is written as {digit5, ..., digit0}.
  task automatic frame(input logic [23:0] codes, input logic tick, input logic ph);
    for (int i = 0; i < 6; i++) begin
      slot(i, codes[4*i +: 4], (i == 0) ? tick : 1'b0, ph);
    end
  endtask

  // No two digit enables may ever be low together.
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      assert ($countones(~dig_sel) <= 1) else begin
        fails++;
        $error("FAIL one_cold observed=%h expected=at most one low bit", dig_sel);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    digits_in  = 24'h123456;
    blink_mask = 6'b000000;
    lz_en      = 1'b0;

    // Reset values while rst_n is low.
    #12;
    chk("rst_sel",   {2'b00, dig_sel}, 8'h3F);
    chk("rst_code",  {4'h0, dec_code}, 8'h0F);
    chk("rst_tick",  {7'd0, frame_tick}, 8'h00);
    chk("rst_phase", {7'd0, blink_phase}, 8'h00);
    rst_n = 1'b1;

    // Frame 0: first frame after OFF carries no tick.
    frame(24'h123456, 1'b0, 1'b0);

    // Frame 1: digits change mid-frame but the snapshot holds.
    slot(0, 4'h6, 1'b1, 1'b0);
    slot(1, 4'h5, 1'b0, 1'b0);
    digits_in = 24'h999999;
    slot(2, 4'h4, 1'b0, 1'b0);
    slot(3, 4'h3, 1'b0, 1'b0);
    slot(4, 4'h2, 1'b0, 1'b0);
    slot(5, 4'h1, 1'b0, 1'b0);

    // Frame 2: new snapshot visible; blink phase flips after two frames.
    frame(24'h999999, 1'b1, 1'b1);
    digits_in  = 24'h123456;
    blink_mask = 6'b000011;

    // Frames 3..6: masked digits blank only in blink-off phase.
    frame(24'h1234FF, 1'b1, 1'b1);
    frame(24'h123456, 1'b1, 1'b0);
    frame(24'h123456, 1'b1, 1'b0);
    frame(24'h1234FF, 1'b1, 1'b1);
    blink_mask = 6'b000000;
    lz_en      = 1'b1;
    digits_in  = 24'h012345;

    // Frame 7: leading zero blanked; frame 8: inner zero kept.
    frame(24'hF12345, 1'b1, 1'b1);
    digits_in = 24'h102345;
    frame(24'h102345, 1'b1, 1'b0);
    frame(24'h102345, 1'b1, 1'b0);

    // Frame 10 (blink-off) interrupted during digit 3 drive.
    slot(0, 4'h5, 1'b1, 1'b1);
    slot(1, 4'h4, 1'b0, 1'b1);
    slot(2, 4'h3, 1'b0, 1'b1);
    step();
    chk("d3_guard_sel", {2'b00, dig_sel}, 8'h3F);
    step();
    chk("d3_drive_sel",  {2'b00, dig_sel}, 8'h37);
    chk("d3_drive_code", {4'h0, dec_code}, 8'h02);
    en = 1'b0;
    step();
    chk("off_sel",   {2'b00, dig_sel}, 8'h3F);
    chk("off_code",  {4'h0, dec_code}, 8'h0F);
    chk("off_tick",  {7'd0, frame_tick}, 8'h00);
    chk("off_phase", {7'd0, blink_phase}, 8'h01);
    step();
    chk("off2_sel",   {2'b00, dig_sel}, 8'h3F);
    chk("off2_phase", {7'd0, blink_phase}, 8'h01);

    // Restart: fresh snapshot, codes A-E pass through, phase retained.
    lz_en     = 1'b0;
    digits_in = 24'hABCDE9;
    en        = 1'b1;
    frame(24'hABCDE9, 1'b0, 1'b1);
    slot(0, 4'h9, 1'b1, 1'b1);
    step();
    chk("r1_guard_sel", {2'b00, dig_sel}, 8'h3F);
    step();
    chk("r1_drive_sel",  {2'b00, dig_sel}, 8'h3D);
    chk("r1_drive_code", {4'h0, dec_code}, 8'h0E);

    // Asynchronous reset mid-slot takes effect without a clock edge.
    rst_n = 1'b0;
    #1;
    chk("arst_sel",   {2'b00, dig_sel}, 8'h3F);
    chk("arst_code",  {4'h0, dec_code}, 8'h0F);
    chk("arst_tick",  {7'd0, frame_tick}, 8'h00);
    chk("arst_phase", {7'd0, blink_phase}, 8'h00);
    #10;
    rst_n = 1'b1;
    slot(0, 4'h9, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
